// File: rtl/goertzel_multibin.sv
// ---------------------------------------------------------------------------
// goertzel_multibin
//
// Time-multiplexed multi-bin Goertzel power detector. One shared
// multiplier datapath walks N_BINS recurrences, one bin per clock, each
// time a sample is accepted. After N_SAMPLES accepted samples the block
// dumps one power word per bin, in ascending bin order, through a
// two-stage pipeline. It then clears its state and starts the next block.
//
// Ports:
//   clock         system clock
//   reset_n       asynchronous active-low reset
//   clear         synchronous abort: zero state/counters, suppress results
//   sample_valid  one-cycle strobe qualifying sample
//   sample        signed input sample (SAMPLE_W)
//   coeff         per-bin 2cos(w), bin k at [k*COEF_W +: COEF_W]
//   busy          high while a sample cannot be accepted
//   sample_lost   pulse: strobe arrived while busy, sample dropped
//   power_valid   pulse per bin result
//   power_bin     bin index of power
//   power         unsigned bin power (held between results)
//   block_done    pulse coincident with the last bin's power_valid
// ---------------------------------------------------------------------------
module goertzel_multibin #(
    parameter int N_BINS      = 4,
    parameter int N_SAMPLES   = 1300,
    parameter int SAMPLE_W    = 32,
    parameter int COEF_W      = 18,
    parameter int COEF_FRAC   = 15,
    parameter int STATE_W     = 56,
    parameter int POWER_W     = 64,
    parameter int POWER_SHIFT = 35,
    localparam int BIN_W      = (N_BINS > 1) ? $clog2(N_BINS) : 1
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic                     clear,
    input  logic                     sample_valid,
    input  logic [SAMPLE_W-1:0]      sample,
    input  logic [N_BINS*COEF_W-1:0] coeff,
    output logic                     busy,
    output logic                     sample_lost,
    output logic                     power_valid,
    output logic [BIN_W-1:0]         power_bin,
    output logic [POWER_W-1:0]       power,
    output logic                     block_done
);

    // The index counts bins in ACCUM and runs two extra steps in DUMP to
    // drain the power pipeline, hence room for N_BINS+1.
    localparam int IDX_W   = $clog2(N_BINS + 2);
    localparam int CNT_W   = $clog2(N_SAMPLES + 1);
    localparam int PROD_W  = COEF_W + STATE_W;
    localparam int SQ_W    = 2 * STATE_W;
    localparam int RAW_W   = 2 * STATE_W + 2;
    localparam int CROSS_W = PROD_W + STATE_W;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DUMP  = 2'd2
    } state_t;

    state_t                     state_q, state_d;
    logic [IDX_W-1:0]           idx_q;
    logic [CNT_W-1:0]           count_q;
    logic signed [SAMPLE_W-1:0] x_q;
    logic signed [STATE_W-1:0]  s1_q [N_BINS];
    logic signed [STATE_W-1:0]  s2_q [N_BINS];

    // Power pipeline stage 1
    logic                       v1_q;
    logic [BIN_W-1:0]           bin1_q;
    logic signed [RAW_W-1:0]    sqSum_q;
    logic signed [PROD_W-1:0]   cs1_q;
    logic signed [STATE_W-1:0]  s2p_q;

    // Output registers
    logic                       power_valid_q;
    logic                       block_done_q;
    logic [POWER_W-1:0]         power_q;
    logic [BIN_W-1:0]           power_bin_q;

    // Combinational datapath
    logic [BIN_W-1:0]           curBin;
    int                         coefBase;
    logic signed [COEF_W-1:0]   curCoef;
    logic signed [STATE_W-1:0]  curS1, curS2;
    logic signed [PROD_W-1:0]   coefProd, coefScaled, accSum;
    logic signed [STATE_W-1:0]  sNew;
    logic signed [SQ_W-1:0]     s1Sq, s2Sq;
    logic signed [RAW_W-1:0]    sqSum;
    logic signed [CROSS_W-1:0]  crossProd;
    logic signed [RAW_W-1:0]    raw, rawClamped;
    logic [POWER_W-1:0]         powerD;
    logic                       lastBin, lastSample, issueDump, dumpEnd;

    // Shared datapath: the same coef*s1 product feeds the recurrence in
    // ACCUM and the cross term of the power in DUMP. During the DUMP drain
    // steps the index exceeds the bin range, so bin 0 is selected harmlessly.
    always_comb begin
        curBin = '0;
        if (idx_q < IDX_W'(N_BINS)) begin
            curBin = idx_q[BIN_W-1:0];
        end
        coefBase   = int'(curBin) * COEF_W;
        curCoef    = coeff[coefBase +: COEF_W];
        curS1      = s1_q[curBin];
        curS2      = s2_q[curBin];
        coefProd   = PROD_W'(curCoef) * PROD_W'(curS1);
        coefScaled = coefProd >>> COEF_FRAC;
        accSum     = PROD_W'(x_q) + coefScaled - PROD_W'(curS2);
        sNew       = STATE_W'(accSum);
        s1Sq       = SQ_W'(curS1) * SQ_W'(curS1);
        s2Sq       = SQ_W'(curS2) * SQ_W'(curS2);
        sqSum      = RAW_W'(s1Sq) + RAW_W'(s2Sq);
        crossProd  = CROSS_W'(cs1_q) * CROSS_W'(s2p_q);
        raw        = sqSum_q - RAW_W'(crossProd);
        rawClamped = raw[RAW_W-1] ? '0 : raw;
        powerD     = POWER_W'(rawClamped >>> POWER_SHIFT);
        lastBin    = (idx_q == IDX_W'(N_BINS - 1));
        lastSample = (count_q == CNT_W'(N_SAMPLES - 1));
        issueDump  = (state_q == DUMP) && (idx_q < IDX_W'(N_BINS));
        dumpEnd    = (state_q == DUMP) && (idx_q == IDX_W'(N_BINS + 1));
    end

    // Next-state logic; clear overrides everything and forces IDLE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (sample_valid) state_d = ACCUM;
            ACCUM:   if (lastBin) state_d = lastSample ? DUMP : IDLE;
            DUMP:    if (dumpEnd) state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (clear) begin
            state_d = IDLE;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // A strobe coincident with clear is swallowed by the abort, so it is
    // not reported as lost.
    assign busy        = (state_q != IDLE);
    assign sample_lost = sample_valid && busy && !clear;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            idx_q         <= '0;
            count_q       <= '0;
            x_q           <= '0;
            for (int k = 0; k < N_BINS; k++) begin
                s1_q[k] <= '0;
                s2_q[k] <= '0;
            end
            v1_q          <= 1'b0;
            bin1_q        <= '0;
            sqSum_q       <= '0;
            cs1_q         <= '0;
            s2p_q         <= '0;
            power_valid_q <= 1'b0;
            block_done_q  <= 1'b0;
            power_q       <= '0;
            power_bin_q   <= '0;
        end else if (clear) begin
            // Dropping v1_q and power_valid_q kills any in-flight result.
            idx_q         <= '0;
            count_q       <= '0;
            for (int k = 0; k < N_BINS; k++) begin
                s1_q[k] <= '0;
                s2_q[k] <= '0;
            end
            v1_q          <= 1'b0;
            power_valid_q <= 1'b0;
            block_done_q  <= 1'b0;
        end else begin
            v1_q          <= issueDump;
            power_valid_q <= v1_q;
            block_done_q  <= v1_q && (bin1_q == BIN_W'(N_BINS - 1));
            if (issueDump) begin
                bin1_q  <= curBin;
                sqSum_q <= sqSum;
                cs1_q   <= coefScaled;
                s2p_q   <= curS2;
            end
            if (v1_q) begin
                power_q     <= powerD;
                power_bin_q <= bin1_q;
            end
            case (state_q)
                IDLE: begin
                    if (sample_valid) begin
                        x_q   <= sample;
                        idx_q <= '0;
                    end
                end
                ACCUM: begin
                    s2_q[curBin] <= curS1;
                    s1_q[curBin] <= sNew;
                    if (lastBin) begin
                        idx_q   <= '0;
                        count_q <= count_q + CNT_W'(1);
                    end else begin
                        idx_q <= idx_q + IDX_W'(1);
                    end
                end
                DUMP: begin
                    if (dumpEnd) begin
                        idx_q   <= '0;
                        count_q <= '0;
                        for (int k = 0; k < N_BINS; k++) begin
                            s1_q[k] <= '0;
                            s2_q[k] <= '0;
                        end
                    end else begin
                        idx_q <= idx_q + IDX_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign power_valid = power_valid_q;
    assign block_done  = block_done_q;
    assign power       = power_q;
    assign power_bin   = power_bin_q;

endmodule

// File: tb/tb_goertzel_multibin.sv
// ---------------------------------------------------------------------------
// tb_goertzel_multibin
//
// Self-checking bench for goertzel_multibin (2 bins, 8-sample blocks,
// no output shift). A reference Goertzel model runs alongside the
// stimulus. When a block's last sample is accepted it queues the expected
// power for each bin. A monitor pops and compares on every power_valid.
// Scenario tasks add their own inline timing/handshake checks.
// ---------------------------------------------------------------------------
module tb_goertzel_multibin;

    localparam int NB  = 2;
    localparam int NS  = 8;
    localparam int SW  = 32;
    localparam int CW  = 18;
    localparam int CF  = 15;
    localparam int STW = 56;
    localparam int PW  = 64;
    localparam int PS  = 0;
    localparam int BW  = 1;
    localparam logic [PW-1:0] DC_POWER = 64'd64000000;

    logic              clock = 1'b0;
    logic              reset_n;
    logic              clear;
    logic              sample_valid;
    logic [SW-1:0]     sample;
    logic [NB*CW-1:0]  coeff;
    logic              busy;
    logic              sample_lost;
    logic              power_valid;
    logic [BW-1:0]     power_bin;
    logic [PW-1:0]     power;
    logic              block_done;

    logic signed [CW-1:0]  coefArr [NB];
    logic signed [STW-1:0] m1 [NB];
    logic signed [STW-1:0] m2 [NB];
    int                    mCount;
    logic [PW-1:0]         lastPower [NB];

    typedef struct {
        int            bin;
        logic [PW-1:0] pw;
    } exp_t;
    exp_t sbQ[$];

    int checks = 0;
    int errors = 0;

    goertzel_multibin #(
        .N_BINS(NB), .N_SAMPLES(NS), .SAMPLE_W(SW), .COEF_W(CW),
        .COEF_FRAC(CF), .STATE_W(STW), .POWER_W(PW), .POWER_SHIFT(PS)
    ) dut (
        .clock(clock), .reset_n(reset_n), .clear(clear),
        .sample_valid(sample_valid), .sample(sample), .coeff(coeff),
        .busy(busy), .sample_lost(sample_lost), .power_valid(power_valid),
        .power_bin(power_bin), .power(power), .block_done(block_done)
    );

    always #5 clock = ~clock;

    always_comb begin
        coeff = '0;
        for (int k = 0; k < NB; k++) begin
            coeff[k*CW +: CW] = coefArr[k];
        end
    end

    // Reference model of one Goertzel step and of the final power.
    function automatic logic signed [127:0] coefTerm(input logic signed [CW-1:0] c,
                                                     input logic signed [STW-1:0] s);
        logic signed [127:0] p;
        p = 128'(c) * 128'(s);
        return p >>> CF;
    endfunction

    task automatic modelReset();
        for (int k = 0; k < NB; k++) begin
            m1[k] = '0;
            m2[k] = '0;
        end
        mCount = 0;
    endtask

    task automatic modelAccept(input logic signed [SW-1:0] x);
        logic signed [127:0] t;
        logic signed [127:0] raw;
        exp_t e;
        for (int k = 0; k < NB; k++) begin
            t     = 128'(x) + coefTerm(coefArr[k], m1[k]) - 128'(m2[k]);
            m2[k] = m1[k];
            m1[k] = t[STW-1:0];
        end
        mCount++;
        if (mCount == NS) begin
            for (int k = 0; k < NB; k++) begin
                raw = 128'(m1[k]) * 128'(m1[k]) + 128'(m2[k]) * 128'(m2[k])
                      - coefTerm(coefArr[k], m1[k]) * 128'(m2[k]);
                if (raw < 0) raw = '0;
                raw  = raw >>> PS;
                e.bin = k;
                e.pw  = raw[PW-1:0];
                sbQ.push_back(e);
            end
            modelReset();
        end
    endtask

    // Scoreboard monitor: every result must match the next queued one.
    always @(negedge clock) begin : monitor
        exp_t e;
        if (power_valid) begin
            checks++;
            if (sbQ.size() == 0) begin
                errors++;
                $display("[TB] FAIL unexpected_power: bin=%0d power=%0d, nothing expected", power_bin, power);
            end else begin
                e = sbQ.pop_front();
                if (power_bin !== BW'(e.bin)) begin
                    errors++;
                    $display("[TB] FAIL power_bin: got %0d expected %0d", power_bin, e.bin);
                end
                checks++;
                if (power !== e.pw) begin
                    errors++;
                    $display("[TB] FAIL power bin%0d: got %0d expected %0d", e.bin, power, e.pw);
                end
                checks++;
                if (block_done !== (e.bin == NB - 1)) begin
                    errors++;
                    $display("[TB] FAIL block_done bin%0d: got %0b expected %0b", e.bin, block_done, (e.bin == NB - 1));
                end
            end
            lastPower[power_bin] = power;
        end else if (block_done) begin
            checks++;
            errors++;
            $display("[TB] FAIL stray_block_done: got 1 expected 0 without power_valid");
        end
    end

    // Drive one strobe once the DUT is idle; leaves at the next negedge.
    task automatic applyStimulus(input logic signed [SW-1:0] val);
        for (int n = 0; busy && n < 60; n++) @(negedge clock);
        if (busy) begin
            checks++;
            errors++;
            $display("[TB] FAIL idle_timeout: busy got 1 expected 0");
        end
        sample       = val;
        sample_valid = 1'b1;
        modelAccept(val);
        @(negedge clock);
        sample_valid = 1'b0;
    endtask

    task automatic waitBlock(output bit seen);
        seen = 1'b0;
        for (int n = 0; n < 80 && !seen; n++) begin
            @(negedge clock);
            if (block_done) seen = 1'b1;
        end
    endtask

    task automatic test_reset();
        $display("[TB] test_reset");
        reset_n = 1'b0; clear = 1'b0; sample_valid = 1'b0; sample = '0;
        coefArr[0] = '0; coefArr[1] = '0;
        modelReset();
        repeat (3) @(negedge clock);
        checks += 6;
        if (busy !== 1'b0)        begin errors++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
        if (sample_lost !== 1'b0) begin errors++; $display("[TB] FAIL reset_lost: got %b expected 0", sample_lost); end
        if (power_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_pvalid: got %b expected 0", power_valid); end
        if (block_done !== 1'b0)  begin errors++; $display("[TB] FAIL reset_done: got %b expected 0", block_done); end
        if (power !== '0)         begin errors++; $display("[TB] FAIL reset_power: got %0d expected 0", power); end
        if (power_bin !== '0)     begin errors++; $display("[TB] FAIL reset_bin: got %0d expected 0", power_bin); end
        reset_n = 1'b1;
        @(negedge clock);
    endtask

    task automatic test_zero_block();
        bit seen;
        $display("[TB] test_zero_block");
        coefArr[0] = '0; coefArr[1] = '0;
        for (int i = 0; i < NS; i++) applyStimulus(0);
        waitBlock(seen);
        checks++;
        if (!seen) begin errors++; $display("[TB] FAIL zero_block_done: got none expected pulse"); end
        @(negedge clock);
    endtask

    // Minimum spacing: each strobe lands in the first idle cycle.
    task automatic test_back_to_back();
        int busyCycles, doneAt;
        $display("[TB] test_back_to_back");
        coefArr[0] = 18'sd65536; coefArr[1] = -18'sd65536;
        for (int i = 0; i < NS; i++) begin
            if (busy) @(negedge clock);
            sample = 1000; sample_valid = 1'b1;
            modelAccept(1000);
            @(negedge clock);
            sample_valid = 1'b0;
            busyCycles = 0; doneAt = 0;
            for (int n = 1; busy && n < 40; n++) begin
                busyCycles++;
                if (block_done) doneAt = n;
                @(negedge clock);
            end
            checks++;
            if (busyCycles != ((i == NS - 1) ? 2 * NB + 2 : NB)) begin
                errors++;
                $display("[TB] FAIL busy_len s%0d: got %0d expected %0d", i, busyCycles, (i == NS - 1) ? 2 * NB + 2 : NB);
            end
        end
        checks++;
        if (doneAt != 2 * NB + 2) begin errors++; $display("[TB] FAIL done_latency: got %0d expected %0d", doneAt, 2 * NB + 2); end
        checks += 2;
        if (lastPower[0] !== DC_POWER) begin errors++; $display("[TB] FAIL dc_bin0: got %0d expected %0d", lastPower[0], DC_POWER); end
        if (lastPower[1] !== '0)       begin errors++; $display("[TB] FAIL dc_bin1: got %0d expected 0", lastPower[1]); end
    endtask

    task automatic test_alternating();
        bit seen;
        $display("[TB] test_alternating");
        for (int i = 0; i < NS; i++) applyStimulus((i % 2 == 0) ? 1000 : -1000);
        waitBlock(seen);
        @(negedge clock);
        checks += 3;
        if (!seen) begin errors++; $display("[TB] FAIL alt_done: got none expected pulse"); end
        if (lastPower[1] !== DC_POWER) begin errors++; $display("[TB] FAIL alt_bin1: got %0d expected %0d", lastPower[1], DC_POWER); end
        if (lastPower[0] !== '0)       begin errors++; $display("[TB] FAIL alt_bin0: got %0d expected 0", lastPower[0]); end
    endtask

    task automatic test_sample_lost();
        bit seen;
        $display("[TB] test_sample_lost");
        for (int n = 0; busy && n < 60; n++) @(negedge clock);
        sample = 1000; sample_valid = 1'b1;
        modelAccept(1000);
        #1;
        checks++;
        if (sample_lost !== 1'b0) begin errors++; $display("[TB] FAIL lost_first: got %b expected 0", sample_lost); end
        @(negedge clock);
        sample = 5000;
        #1;
        checks++;
        if (sample_lost !== 1'b1) begin errors++; $display("[TB] FAIL lost_second: got %b expected 1", sample_lost); end
        @(negedge clock);
        sample_valid = 1'b0;
        #1;
        checks++;
        if (sample_lost !== 1'b0) begin errors++; $display("[TB] FAIL lost_after: got %b expected 0", sample_lost); end
        for (int i = 1; i < NS; i++) applyStimulus(1000);
        waitBlock(seen);
        @(negedge clock);
        checks += 2;
        if (!seen) begin errors++; $display("[TB] FAIL lost_done: got none expected pulse"); end
        if (lastPower[0] !== DC_POWER) begin errors++; $display("[TB] FAIL lost_bin0: got %0d expected %0d", lastPower[0], DC_POWER); end
    endtask

    task automatic test_clear();
        bit seen;
        $display("[TB] test_clear");
        for (int i = 0; i < 5; i++) applyStimulus(1000);
        clear = 1'b1; sample_valid = 1'b1; sample = 7777;
        #1;
        checks++;
        if (sample_lost !== 1'b0) begin errors++; $display("[TB] FAIL clear_nolost: got %b expected 0", sample_lost); end
        @(negedge clock);
        clear = 1'b0; sample_valid = 1'b0;
        modelReset();
        checks++;
        if (busy !== 1'b0) begin errors++; $display("[TB] FAIL clear_idle: got %b expected 0", busy); end
        for (int i = 0; i < NS; i++) applyStimulus(1000);
        waitBlock(seen);
        @(negedge clock);
        checks += 2;
        if (!seen) begin errors++; $display("[TB] FAIL clear_done: got none expected pulse"); end
        if (lastPower[0] !== DC_POWER) begin errors++; $display("[TB] FAIL clear_bin0: got %0d expected %0d", lastPower[0], DC_POWER); end
    endtask

    // Clear lands one cycle before the first result would appear.
    task automatic test_clear_dump();
        int pulses;
        $display("[TB] test_clear_dump");
        for (int i = 0; i < NS; i++) applyStimulus(1000);
        repeat (3) @(negedge clock);
        clear = 1'b1;
        @(negedge clock);
        clear = 1'b0;
        checks++;
        if (busy !== 1'b0) begin errors++; $display("[TB] FAIL cdump_idle: got %b expected 0", busy); end
        pulses = 0;
        for (int n = 0; n < 8; n++) begin
            if (power_valid) pulses++;
            @(negedge clock);
        end
        checks++;
        if (pulses != 0) begin errors++; $display("[TB] FAIL cdump_suppress: got %0d pulses expected 0", pulses); end
        sbQ.delete();
    endtask

    task automatic test_reset_dump();
        bit seen;
        $display("[TB] test_reset_dump");
        for (int i = 0; i < NS; i++) applyStimulus(1000);
        seen = 1'b0;
        for (int n = 0; n < 40 && !seen; n++) begin
            @(negedge clock);
            if (power_valid) seen = 1'b1;
        end
        checks += 2;
        if (!seen) begin errors++; $display("[TB] FAIL rdump_first: got none expected pulse"); end
        if (power_bin !== '0) begin errors++; $display("[TB] FAIL rdump_bin0: got %0d expected 0", power_bin); end
        #1;
        reset_n = 1'b0;
        #1;
        checks += 4;
        if (power_valid !== 1'b0) begin errors++; $display("[TB] FAIL rdump_pvalid: got %b expected 0", power_valid); end
        if (power !== '0)         begin errors++; $display("[TB] FAIL rdump_power: got %0d expected 0", power); end
        if (busy !== 1'b0)        begin errors++; $display("[TB] FAIL rdump_busy: got %b expected 0", busy); end
        if (block_done !== 1'b0)  begin errors++; $display("[TB] FAIL rdump_done: got %b expected 0", block_done); end
        sbQ.delete();
        modelReset();
        repeat (3) @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);
        for (int i = 0; i < NS; i++) applyStimulus(1000);
        waitBlock(seen);
        @(negedge clock);
        checks += 2;
        if (!seen) begin errors++; $display("[TB] FAIL rdump_again: got none expected pulse"); end
        if (lastPower[0] !== DC_POWER) begin errors++; $display("[TB] FAIL rdump_bin0_again: got %0d expected %0d", lastPower[0], DC_POWER); end
    endtask

    task automatic test_random_blocks();
        bit seen;
        $display("[TB] test_random_blocks");
        for (int b = 0; b < 2; b++) begin
            for (int k = 0; k < NB; k++) coefArr[k] = CW'(int'($urandom_range(0, 131071)) - 65536);
            for (int i = 0; i < NS; i++) applyStimulus(SW'(int'($urandom_range(0, 20000)) - 10000));
            waitBlock(seen);
            checks++;
            if (!seen) begin errors++; $display("[TB] FAIL rand_done b%0d: got none expected pulse", b); end
        end
        @(negedge clock);
    endtask

    initial begin : watchdog
        #300000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        lastPower[0] = '0; lastPower[1] = '0;
        test_reset();
        test_zero_block();
        test_back_to_back();
        test_alternating();
        test_sample_lost();
        test_clear();
        test_clear_dump();
        test_reset_dump();
        test_random_blocks();
        repeat (4) @(negedge clock);
        checks++;
        if (sbQ.size() != 0) begin errors++; $display("[TB] FAIL sb_drain: got %0d pending expected 0", sbQ.size()); end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
